// File: rtl/sbus_mem_responder.sv
// SBUS memory responder: answers MEM START with ACKN, then one DATA VALID per requested word.
// Latency: ACKN ACK_DLY+1 clocks after the MEM START rise; first read word RD_DLY+1 clocks after ACKN.
// Backpressure: none; writes advance only on i_mem_wr_stb, and dropping i_mem_start aborts the transfer.
//
// Optional macro SBUS_RESP_PARITY_EN: enables the address parity check and read data parity.
// Without it, i_mem_adr_par is ignored and both parity outputs are tied low.
//
// Ports:
//   i_clk, i_reset_l        MBOX clock, asynchronous active-low reset
//   i_mem_start             request strobe (level, held until last DATA VALID or NXM)
//   i_mem_rd_rq/i_mem_wr_rq read / write request (both set = read-pause-write)
//   i_mem_rq[3:0]           word request mask, bit i = word i of the quad
//   i_mem_adr[21:0]         physical word address; bit 0 is PDP-10 bit 35, [1:0] is the starting word
//   i_mem_adr_par           odd parity over i_mem_adr
//   i_mem_wr_data/_stb      write data and strobe for the current word
//   o_ackn_pulse            one-cycle acknowledge
//   o_data_valid            one-cycle pulse per word transferred
//   o_mem_rd_data           read data, held until the next read DATA VALID
//   o_mem_par_out           odd parity over o_mem_rd_data
//   o_mem_adr_par_err       address parity error, held until the next MEM START rise
//   o_busy                  high whenever the responder is not idle
module sbus_mem_responder #(
  parameter int ADR_W   = 10,
  parameter int ACK_DLY = 2,
  parameter int RD_DLY  = 3
) (
  input  logic        i_clk,
  input  logic        i_reset_l,
  input  logic        i_mem_start,
  input  logic        i_mem_rd_rq,
  input  logic        i_mem_wr_rq,
  input  logic [3:0]  i_mem_rq,
  input  logic [21:0] i_mem_adr,
  input  logic        i_mem_adr_par,
  input  logic [35:0] i_mem_wr_data,
  input  logic        i_mem_wr_stb,
  output logic        o_ackn_pulse,
  output logic        o_data_valid,
  output logic [35:0] o_mem_rd_data,
  output logic        o_mem_par_out,
  output logic        o_mem_adr_par_err,
  output logic        o_busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACKW, S_RDD, S_RDX, S_WRX, S_DONE, S_NXM
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_start_q;
  logic [3:0]       r_cnt, w_cnt_nxt;
  logic [ADR_W-3:0] r_qadr, w_qadr_nxt;
  logic [1:0]       r_sword, w_sword_nxt;
  logic [1:0]       r_ptr, w_ptr_nxt;
  logic [3:0]       r_rq, w_rq_nxt;
  logic [3:0]       r_rq_lat, w_rq_lat_nxt;
  logic             r_rd, w_rd_nxt;
  logic             r_wr, w_wr_nxt;
  logic             r_ackn, w_ackn_nxt;
  logic             r_dv, w_dv_nxt;
  logic [35:0]      r_rd_data;
  logic             w_rd_load, w_we;
  logic             w_start_cond, w_nxm;
  logic [1:0]       w_sel, w_pos;
  logic [3:0]       w_rq_clr;
  logic             w_last;
  logic [ADR_W-1:0] w_midx;

  logic [35:0] r_mem [2**ADR_W];

  // Only a genuine rise starts a request; a level held across DONE/NXM never retriggers.
  assign w_start_cond = (r_state == S_IDLE) && i_mem_start && !r_start_q &&
                        (i_mem_rd_rq || i_mem_wr_rq) && (i_mem_rq != 4'd0);
  assign w_nxm        = (i_mem_adr >> ADR_W) != 22'd0;

  // First requested word at or after the pointer, wrapping 3 -> 0.
  // Scanning from the far end lets the nearest set bit win.
  always_comb begin
    w_sel = r_ptr;
    w_pos = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      w_pos = r_ptr + 2'(k);
      if (r_rq[w_pos]) w_sel = w_pos;
    end
  end

  assign w_rq_clr = r_rq & ~(4'b0001 << w_sel);
  assign w_last   = (w_rq_clr == 4'd0);
  assign w_midx   = {r_qadr, w_sel};

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_qadr_nxt   = r_qadr;
    w_sword_nxt  = r_sword;
    w_ptr_nxt    = r_ptr;
    w_rq_nxt     = r_rq;
    w_rq_lat_nxt = r_rq_lat;
    w_rd_nxt     = r_rd;
    w_wr_nxt     = r_wr;
    w_ackn_nxt   = 1'b0;
    w_dv_nxt     = 1'b0;
    w_rd_load    = 1'b0;
    w_we         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_cond) begin
          if (w_nxm) begin
            w_state_nxt = S_NXM;
          end else begin
            w_qadr_nxt   = i_mem_adr[ADR_W-1:2];
            w_sword_nxt  = i_mem_adr[1:0];
            w_ptr_nxt    = i_mem_adr[1:0];
            w_rq_nxt     = i_mem_rq;
            w_rq_lat_nxt = i_mem_rq;
            w_rd_nxt     = i_mem_rd_rq;
            w_wr_nxt     = i_mem_wr_rq;
            w_cnt_nxt    = 4'd0;
            w_state_nxt  = S_ACKW;
          end
        end
      end
      S_ACKW: begin
        if (!i_mem_start) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == 4'(ACK_DLY - 1)) begin
          w_ackn_nxt  = 1'b1;
          w_cnt_nxt   = 4'd0;
          w_state_nxt = r_rd ? S_RDD : S_WRX;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_RDD: begin
        if (!i_mem_start) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == 4'(RD_DLY - 1)) begin
          w_state_nxt = S_RDX;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_RDX: begin
        if (!i_mem_start) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_rd_load = 1'b1;
          w_dv_nxt  = 1'b1;
          w_rq_nxt  = w_rq_clr;
          w_ptr_nxt = w_sel + 2'd1;
          if (w_last) begin
            if (r_wr) begin
              // Read-pause-write: replay the same words for the write half.
              w_rq_nxt    = r_rq_lat;
              w_ptr_nxt   = r_sword;
              w_state_nxt = S_WRX;
            end else begin
              w_state_nxt = S_DONE;
            end
          end
        end
      end
      S_WRX: begin
        if (!i_mem_start) begin
          w_state_nxt = S_IDLE;
        end else if (i_mem_wr_stb) begin
          w_we      = 1'b1;
          w_dv_nxt  = 1'b1;
          w_rq_nxt  = w_rq_clr;
          w_ptr_nxt = w_sel + 2'd1;
          if (w_last) w_state_nxt = S_DONE;
        end
      end
      S_DONE, S_NXM: begin
        if (!i_mem_start) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_l) begin
    if (!i_reset_l) begin
      r_state   <= S_IDLE;
      r_start_q <= 1'b0;
      r_cnt     <= 4'd0;
      r_qadr    <= '0;
      r_sword   <= 2'd0;
      r_ptr     <= 2'd0;
      r_rq      <= 4'd0;
      r_rq_lat  <= 4'd0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_ackn    <= 1'b0;
      r_dv      <= 1'b0;
      r_rd_data <= 36'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_start_q <= i_mem_start;
      r_cnt     <= w_cnt_nxt;
      r_qadr    <= w_qadr_nxt;
      r_sword   <= w_sword_nxt;
      r_ptr     <= w_ptr_nxt;
      r_rq      <= w_rq_nxt;
      r_rq_lat  <= w_rq_lat_nxt;
      r_rd      <= w_rd_nxt;
      r_wr      <= w_wr_nxt;
      r_ackn    <= w_ackn_nxt;
      r_dv      <= w_dv_nxt;
      if (w_rd_load) r_rd_data <= r_mem[w_midx];
    end
  end

  // Backing store has no reset; contents survive a reset.
  always_ff @(posedge i_clk) begin
    if (w_we) r_mem[w_midx] <= i_mem_wr_data;
  end

`ifdef SBUS_RESP_PARITY_EN
  logic r_par, r_par_err;

  always_ff @(posedge i_clk or negedge i_reset_l) begin
    if (!i_reset_l) begin
      r_par     <= 1'b0;
      r_par_err <= 1'b0;
    end else begin
      if (w_rd_load) r_par <= ~^r_mem[w_midx];
      // Error flag is rearmed by every rise; a bad address is still serviced.
      if (w_start_cond)                    r_par_err <= ~^{i_mem_adr, i_mem_adr_par};
      else if (i_mem_start && !r_start_q)  r_par_err <= 1'b0;
    end
  end

  assign o_mem_par_out     = r_par;
  assign o_mem_adr_par_err = r_par_err;
`else
  logic w_unused;
  assign w_unused          = i_mem_adr_par;
  assign o_mem_par_out     = 1'b0;
  assign o_mem_adr_par_err = 1'b0;
`endif

  assign o_ackn_pulse  = r_ackn;
  assign o_data_valid  = r_dv;
  assign o_mem_rd_data = r_rd_data;
  assign o_busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_sbus_mem_responder.sv
`timescale 1ns/1ps
module tb_sbus_mem_responder;
  localparam int ADR_W   = 10;
  localparam int ACK_DLY = 2;
  localparam int RD_DLY  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, rd_rq = 1'b0, wr_rq = 1'b0;
  logic [3:0]  rq = 4'd0;
  logic [21:0] adr = 22'd0;
  logic        adr_par = 1'b0;
  logic [35:0] wr_data = 36'd0;
  logic        wr_stb = 1'b0;
  logic        ackn, dv, par_out, par_err, busy;
  logic [35:0] rd_data;

  sbus_mem_responder #(.ADR_W(ADR_W), .ACK_DLY(ACK_DLY), .RD_DLY(RD_DLY)) dut (
    .i_clk(clk), .i_reset_l(rst_n), .i_mem_start(start), .i_mem_rd_rq(rd_rq),
    .i_mem_wr_rq(wr_rq), .i_mem_rq(rq), .i_mem_adr(adr), .i_mem_adr_par(adr_par),
    .i_mem_wr_data(wr_data), .i_mem_wr_stb(wr_stb), .o_ackn_pulse(ackn),
    .o_data_valid(dv), .o_mem_rd_data(rd_data), .o_mem_par_out(par_out),
    .o_mem_adr_par_err(par_err), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [35:0] mem_m [1 << ADR_W];
  bit          use_fixed = 1'b0;
  logic [35:0] fixed_wd = 36'd0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic exp_par(input logic [35:0] d);
`ifdef SBUS_RESP_PARITY_EN
    return ($countones(d) % 2) == 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic exp_perr(input bit badpar);
`ifdef SBUS_RESP_PARITY_EN
    return badpar;
`else
    return 1'b0;
`endif
  endfunction

  task automatic drive_req(input bit rd, input bit wr, input logic [21:0] a,
                           input logic [3:0] r, input bit badpar);
    rd_rq   = rd;
    wr_rq   = wr;
    rq      = r;
    adr     = a;
    adr_par = (($countones(a) % 2) == 0) ^ badpar;
    start   = 1'b1;
  endtask

  task automatic release_req();
    start  = 1'b0;
    wr_stb = 1'b0;
    @(negedge clk);
    check_val("busy_idle", 64'(busy), 64'd0);
  endtask

  // Waits up to 20 cycles for ACKN (sel=0) or DATA VALID (sel=1).
  task automatic wait_for(input bit sel, input string tag, output bit found);
    found = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if ((sel ? dv : ackn) === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check_val(tag, 64'(found), 64'd1);
  endtask

  // One complete request; expected timing and data come from plain arithmetic on the model.
  task automatic xfer(input bit rd, input bit wr, input logic [21:0] a,
                      input logic [3:0] r, input bit badpar);
    int order[$];
    int cyc, got, ack_cyc, base, idx, extra, gap;
    logic [35:0] wd;
    order = {};
    for (int k = 0; k < 4; k++)
      if (r[(int'(a[1:0]) + k) % 4]) order.push_back((int'(a[1:0]) + k) % 4);
    base = (int'(a) % (1 << ADR_W)) - int'(a[1:0]);
    @(negedge clk);
    drive_req(rd, wr, a, r, badpar);
    cyc = 0; got = -1; extra = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk); cyc++;
      if (dv) extra++;
      if (ackn) begin got = cyc; break; end
    end
    check_val("ack_lat", 64'(got), 64'(ACK_DLY + 1));
    check_val("dv_before_ack", 64'(extra), 64'd0);
    check_val("adr_par_err", 64'(par_err), 64'(exp_perr(badpar)));
    if (got < 0) begin release_req(); return; end
    ack_cyc = got;
    extra = 0;
    if (rd) begin
      foreach (order[i]) begin
        got = -1;
        for (int t = 0; t < 20; t++) begin
          @(negedge clk); cyc++;
          if (ackn) extra++;
          if (dv) begin got = cyc; break; end
        end
        check_val("rd_lat", 64'(got), 64'(ack_cyc + RD_DLY + 1 + i));
        if (got < 0) begin release_req(); return; end
        idx = base + order[i];
        check_val("rd_data", 64'(rd_data), 64'(mem_m[idx]));
        check_val("rd_par", 64'(par_out), 64'(exp_par(mem_m[idx])));
      end
      check_val("ack_once", 64'(extra), 64'd0);
    end
    if (wr) begin
      foreach (order[i]) begin
        gap = $urandom_range(0, 2);
        repeat (gap) begin
          wr_stb = 1'b0;
          @(negedge clk);
          check_val("wr_gap_dv", 64'(dv), 64'd0);
        end
        wd = use_fixed ? fixed_wd : {4'($urandom), $urandom};
        wr_data = wd;
        wr_stb  = 1'b1;
        @(negedge clk);
        check_val("wr_dv", 64'(dv), 64'd1);
        mem_m[base + order[i]] = wd;
      end
      wr_stb = 1'b0;
    end
    repeat (2) begin
      @(negedge clk);
      check_val("done_quiet", 64'(dv | ackn), 64'd0);
    end
    check_val("busy_done", 64'(busy), 64'd1);
    release_req();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   ok;
    int   cnt, kind;
    logic [21:0] ra;
    // Reset state, checked while reset is still asserted.
    #2;
    check_val("rst_ackn", 64'(ackn), 64'd0);
    check_val("rst_dv", 64'(dv), 64'd0);
    check_val("rst_data", 64'(rd_data), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_par", 64'({par_out, par_err}), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Preload words 0..63 with full-quad writes at random starting words.
    for (int q = 0; q < 16; q++) xfer(1'b0, 1'b1, 22'(q * 4 + int'($urandom_range(0, 3))), 4'hF, 1'b0);

    // Single read of word 5 after writing a known value.
    use_fixed = 1'b1; fixed_wd = 36'o123456701234;
    xfer(1'b0, 1'b1, 22'd5, 4'b0010, 1'b0);
    use_fixed = 1'b0;
    xfer(1'b1, 1'b0, 22'd5, 4'b0010, 1'b0);

    // Wrapped quad read starting at word 2 of the quad.
    xfer(1'b1, 1'b0, 22'd6, 4'b1111, 1'b0);

    // Read-pause-write, then re-read.
    use_fixed = 1'b1; fixed_wd = 36'o777;
    xfer(1'b1, 1'b1, 22'd8, 4'b0001, 1'b0);
    use_fixed = 1'b0;
    xfer(1'b1, 1'b0, 22'd8, 4'b0001, 1'b0);

    // Read data with a single bit set, and a bad address parity.
    use_fixed = 1'b1; fixed_wd = 36'o1;
    xfer(1'b0, 1'b1, 22'd9, 4'b0010, 1'b0);
    use_fixed = 1'b0;
    xfer(1'b1, 1'b0, 22'd9, 4'b0010, 1'b0);
    xfer(1'b1, 1'b0, 22'd5, 4'b0010, 1'b1);

    // Randomized reads, writes and read-pause-writes.
    for (int n = 0; n < 25; n++) begin
      kind = $urandom_range(0, 2);
      xfer(kind != 1, kind != 0, 22'($urandom_range(0, 63)), 4'($urandom_range(1, 15)), 1'b0);
    end

    // Ignored rises: empty mask, then no RD/WR.
    @(negedge clk);
    drive_req(1'b1, 1'b0, 22'd4, 4'd0, 1'b0);
    cnt = 0;
    repeat (4) begin @(negedge clk); cnt += int'(busy) + int'(ackn); end
    start = 1'b0;
    @(negedge clk);
    drive_req(1'b0, 1'b0, 22'd4, 4'hF, 1'b0);
    repeat (4) begin @(negedge clk); cnt += int'(busy) + int'(ackn); end
    check_val("ignored_start", 64'(cnt), 64'd0);
    start = 1'b0;
    @(negedge clk);

    // NXM: nothing for 64 cycles while held.
    drive_req(1'b1, 1'b0, 22'o4000, 4'b0001, 1'b0);
    cnt = 0;
    repeat (64) begin @(negedge clk); cnt += int'(ackn) + int'(dv); end
    check_val("nxm_quiet", 64'(cnt), 64'd0);
    check_val("nxm_busy", 64'(busy), 64'd1);
    release_req();

    // Abort in RDD.
    @(negedge clk);
    drive_req(1'b1, 1'b0, 22'd5, 4'b0010, 1'b0);
    wait_for(1'b0, "abort_ack", ok);
    start = 1'b0;
    @(negedge clk);
    check_val("abort_busy", 64'(busy), 64'd0);
    cnt = 0;
    repeat (10) begin @(negedge clk); cnt += int'(dv); end
    check_val("abort_no_dv", 64'(cnt), 64'd0);

    // Partial write aborted after two words; re-read shows the mix.
    drive_req(1'b0, 1'b1, 22'd12, 4'hF, 1'b0);
    wait_for(1'b0, "pw_ack", ok);
    for (int w = 0; w < 2; w++) begin
      wr_data = {4'($urandom), $urandom};
      wr_stb  = 1'b1;
      @(negedge clk);
      check_val("pw_dv", 64'(dv), 64'd1);
      mem_m[12 + w] = wr_data;
    end
    start = 1'b0; wr_stb = 1'b0;
    @(negedge clk);
    check_val("pw_busy", 64'(busy), 64'd0);
    xfer(1'b1, 1'b0, 22'd12, 4'hF, 1'b0);

    // Reset in RDX clears outputs without waiting for a clock.
    @(negedge clk);
    drive_req(1'b1, 1'b0, 22'd16, 4'hF, 1'b0);
    wait_for(1'b1, "rst_rdx_dv", ok);
    #1 rst_n = 1'b0;
    #1;
    check_val("arst_dv", 64'(dv), 64'd0);
    check_val("arst_data", 64'(rd_data), 64'd0);
    check_val("arst_busy", 64'(busy), 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    xfer(1'b1, 1'b0, 22'd16, 4'hF, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sbus_mem_responder.md
Name: sbus_mem_responder

Overview:
- Memory-side responder for the SBUS memory protocol that the MBOX core-busy/NXM logic drives.
- Accepts MEM START with RD/WR request and a quad-word request mask.
- Returns a one-cycle ACKN pulse, then one DATA VALID pulse per requested word, wrapping mod 4 from the starting word.
- Addresses outside the populated range get no response, so the initiator's NXM timer expires; used as a bench memory and as the FPGA core-memory stub.

Parameters:
- ADR_W, 10, log2 of populated words in the backing array.
- ACK_DLY, 2, cycles from MEM START sampled to ACKN pulse (1..15).
- RD_DLY, 3, cycles from ACKN to first read DATA VALID (1..15).

Ports:
- clk  in  1  MBOX clock.
- RESET_L  in  1  asynchronous active-low reset.
- MEM_START  in  1  request strobe, level, held by initiator until it sees the last DATA VALID (or NXM).
- MEM_RD_RQ  in  1  read request; with MEM_WR_RQ set = read-pause-write.
- MEM_WR_RQ  in  1  write request.
- MEM_RQ  in  4  word request mask, bit i = word i of the quad.
- MEM_ADR  in  22  physical word address [14:35]; [34:35] is the starting word.
- MEM_ADR_PAR  in  1  odd parity over MEM_ADR.
- MEM_WR_DATA  in  36  write data for the current word.
- MEM_WR_STB  in  1  write data valid for the current word.
- ACKN_PULSE  out  1  one-cycle acknowledge.
- DATA_VALID  out  1  one-cycle per word transferred (read: data on MEM_RD_DATA; write: word accepted).
- MEM_RD_DATA  out  36  read data.
- MEM_PAR_OUT  out  1  odd parity over MEM_RD_DATA.
- MEM_ADR_PAR_ERR  out  1  address parity error, level until next MEM_START rise.
- BUSY  out  1  high in any state but IDLE.

Behaviour:
- Reset (async, RESET_L=0): state IDLE; all outputs 0; word pointer 0; array contents undefined.
- IDLE:
  - Start condition: MEM_START rising edge (registered compare with last value) with RD or WR set and MEM_RQ nonzero.
  - If MEM_ADR >= 2**ADR_W: go to NXM.
  - Otherwise latch ADR, RQ, RD, WR; set pointer = ADR[34:35]; go to ACKW.
  - MEM_START rise with RQ=0, or with neither RD nor WR: ignored, stay IDLE.
- ACKW: count ACK_DLY cycles, then ACKN_PULSE=1 for exactly one cycle.
  - Next state RDD if RD, else WRX.
- RDD: count RD_DLY cycles, then RDX.
- RDX: each cycle, find the next set RQ bit at or after pointer (wrap 3->0).
  - Drive MEM_RD_DATA = array[{ADR[14+..33], ptr}], DATA_VALID=1, clear that RQ bit, advance pointer.
  - On the last word: RD-only goes to DONE; read-pause-write reloads RQ from the latch and goes to WRX.
  - Read data is held until the next DATA_VALID.
- WRX: wait for MEM_WR_STB.
  - Each strobe writes MEM_WR_DATA to the current word, pulses DATA_VALID the following cycle, and advances as in RDX.
  - After the last word, go to DONE.
  - A strobe arriving in the DATA_VALID cycle is accepted back-to-back.
- DONE: wait for MEM_START=0, then IDLE. A new request needs a fresh rising edge.
- NXM: no ACKN, no DATA_VALID, no write. Stay until MEM_START=0, then IDLE.
- Reset mid-transfer: aborts immediately. A partial write leaves already-written words updated.
- MEM_START dropping in ACKW/RDD/RDX/WRX aborts the transfer: go to IDLE next cycle, no further pulses.
- Latency, single word read: ACKN at ACK_DLY+1 cycles after the MEM_START rise; DATA_VALID RD_DLY+1 cycles after ACKN.

Optional Feature:
- Macro SBUS_RESP_PARITY_EN.
- With the macro:
  - MEM_ADR_PAR is checked at the start condition. A mismatch sets MEM_ADR_PAR_ERR; the request is still acknowledged and executed.
  - MEM_PAR_OUT is odd parity of MEM_RD_DATA, registered with the data.
- Without the macro:
  - MEM_ADR_PAR is ignored.
  - MEM_ADR_PAR_ERR and MEM_PAR_OUT are tied 0.
  - No parity logic is synthesized.

Test Plan:
- Single read, defaults: preload array[5]=36'o123456701234; MEM_START with RD, ADR=5, RQ=4'b0010 -> ACKN at cycle 3, DATA_VALID at cycle 7, data 36'o123456701234, then DONE.
- Wrapped quad read: ADR[34:35]=2, RQ=4'b1111 -> four DATA_VALID pulses on consecutive cycles, words 2,3,0,1.
- Read-pause-write: RD+WR, ADR=8, RQ=4'b0001 -> read returns the old value, then MEM_WR_STB with 36'o777 -> DATA_VALID; a re-read returns 36'o777.
- NXM: ADR=22'o4000 with ADR_W=10 -> no ACKN or DATA_VALID for 64 cycles while MEM_START is held; drop MEM_START -> IDLE, BUSY=0.
- Abort and reset: drop MEM_START during RDD -> no DATA_VALID, IDLE next cycle; RESET_L low during RDX -> all outputs 0 asynchronously.
- Parity (macro on): MEM_ADR_PAR wrong for ADR=5 -> MEM_ADR_PAR_ERR=1 and transfer completes; read data 36'o1 -> MEM_PAR_OUT=0.
